id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline boundary of the 5-stage core; registers decoded operands and control from the decode stage and presents forwarded ALU operands (src_a_e, src_b_e, alu_control_e) to the execute-stage ALU.
Owns stall/flush/bubble handling for the EX slot and MEM/WB-to-EX operand forwarding.
Keeps held operands coherent while stalled, so no writeback is lost.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register-address width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
stall_e  in  1  hold EX-slot contents
flush_e  in  1  load a bubble into the EX slot
valid_d  in  1  decode slot holds a real instruction
rd1_d, rd2_d  in  XLEN  register-file read data
rs1_d, rs2_d, rd_d  in  REG_AW  source/destination register numbers
imm_ext_d, pc_d  in  XLEN  extended immediate, instruction PC
alu_control_d  in  3  ALU operation (package encoding)
alu_src_d, reg_write_d, mem_write_d, branch_d, jump_d  in  1  control bits
result_src_d  in  2  writeback mux select
alu_result_m  in  XLEN  MEM-stage ALU result
rd_m  in  REG_AW  MEM-stage destination register
reg_write_m  in  1  MEM-stage write enable
result_w  in  XLEN  WB-stage result
rd_w  in  REG_AW  WB-stage destination register
reg_write_w  in  1  WB-stage write enable
src_a_e, src_b_e  out  XLEN  ALU operands
write_data_e  out  XLEN  forwarded rs2 data for stores
alu_control_e  out  3  registered ALU operation
pc_e, imm_ext_e  out  XLEN  registered PC and immediate
rs1_e, rs2_e, rd_e  out  REG_AW  registered register numbers (to hazard unit)
reg_write_e, mem_write_e, branch_e, jump_e, valid_e  out  1  registered control
result_src_e  out  2  registered writeback select
forward_a_e, forward_b_e  out  2  forwarding select (debug and hazard unit)

Behaviour:
- Reset is synchronous and active-high. On reset, every registered field clears to 0, so valid_e=0 and all write/branch/jump controls are 0 (a bubble). Reset beats flush, and flush beats stall.
- Normal operation (no reset, flush_e or stall_e): every *_d field is captured into its *_e register on the edge. Latency is 1 cycle.
- flush_e=1: load a bubble. valid_e, reg_write_e, mem_write_e, branch_e, jump_e, alu_control_e, result_src_e and rd_e clear to 0. Data fields clear to 0.
- stall_e=1 (with flush_e=0): all fields hold, except the stall refresh rule below.
- Stall refresh: while stalled, if reg_write_w=1, rd_w!=0 and rd_w==rs1_e, the held rd1 register loads result_w. The same applies to rs2_e and the held rd2 register.
- Forwarding is combinational from the registered rs1_e/rs2_e. For each operand, checked in priority order:
  - FWD_M (2'b10) if reg_write_m and rd_m!=0 and rd_m==rs_e;
  - else FWD_W (2'b01) if reg_write_w and rd_w!=0 and rd_w==rs_e;
  - else FWD_NONE (2'b00).
- MEM always wins over WB. Register x0 is never forwarded. 2'b11 is never produced.
- Operand muxes:
  - src_a_e = forwarded rs1 value.
  - write_data_e = forwarded rs2 value.
  - src_b_e = imm_ext_e when alu_src_e=1, else write_data_e.
- Forward select outputs are driven whether or not valid_e=1. Downstream gates side effects with valid_e.
- alu_control_e is opaque to this block. It is passed through unmodified.
- No arithmetic happens here. Widths are exact XLEN with no extension.

Decomposition:
- Package riscv_pkg holds:
  - ALU_ADD/ALU_SUB/ALU_AND/ALU_OR/ALU_SLT encodings (3-bit);
  - fwd_sel_t enum (FWD_NONE, FWD_W, FWD_M);
  - result_src encodings;
  - XLEN/REG_AW constants.
- Sub-module forward_unit is purely combinational. It takes rs_e, rd_m, reg_write_m, rd_w and reg_write_w, and returns fwd_sel_t. It is instantiated twice.

Test Plan:
- Reset held 2 cycles with arbitrary _d inputs -> all outputs 0, valid_e=0; first edge after release captures _d.
- Back-to-back dependency: rd_m=5, reg_write_m=1, alu_result_m=0x10, rs1_e=5, rd1 reg=0x99 -> forward_a_e=10, src_a_e=0x10. Also rd_w=5, result_w=0x20 -> MEM still wins, src_a_e=0x10.
- x0 guard: rd_m=0, reg_write_m=1, rs2_e=0, alu_src_e=0 -> forward_b_e=00, src_b_e=held rd2.
- Stall refresh: stall_e=1 for 2 cycles, rs1_e=7, WB writes x7=0xABCD in cycle 1 -> after the stall ends with no forwarding active, src_a_e=0xABCD.
- Simultaneous flush_e=1 and stall_e=1 with reg_write_d=1 -> next cycle valid_e=0, reg_write_e=0, mem_write_e=0.
- alu_src_d=1, imm_ext_d=0xFFFFF800, rs2 forwarded -> src_b_e=0xFFFFF800, write_data_e=forwarded value.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings, widths and payload types for the 5-stage core.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned ALU_W  = 3;
    localparam int unsigned RSRC_W = 2;

    // ALU operation encodings (opaque to the ID/EX boundary)
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

    // Writeback mux select encodings
    localparam logic [RSRC_W-1:0] RES_ALU = 2'b00;
    localparam logic [RSRC_W-1:0] RES_MEM = 2'b01;
    localparam logic [RSRC_W-1:0] RES_PC4 = 2'b10;

    // Operand forwarding select; 2'b11 is never produced
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_t;

    // Control bundle carried through the EX slot
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic              alu_src;
        logic [RSRC_W-1:0] result_src;
        logic [ALU_W-1:0]  alu_control;
    } ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// Selects the source of one EX operand; MEM beats WB and x0 is never forwarded.
module forward_unit #(
    parameter int unsigned REG_AW = riscv_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    output riscv_pkg::fwd_sel_t sel_c
);
    import riscv_pkg::*;

    // Priority compare against the MEM then WB destination
    always_comb begin
        sel_c = FWD_NONE;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            sel_c = FWD_M;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            sel_c = FWD_W;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble/stall handling and MEM/WB-to-EX forwarding.
module id_ex_stage #(
    parameter int unsigned XLEN   = riscv_pkg::XLEN,
    parameter int unsigned REG_AW = riscv_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic              valid_d,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic [XLEN-1:0]   imm_ext_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [2:0]        alu_control_d,
    input  logic              alu_src_d,
    input  logic              reg_write_d,
    input  logic              mem_write_d,
    input  logic              branch_d,
    input  logic              jump_d,
    input  logic [1:0]        result_src_d,
    input  logic [XLEN-1:0]   alu_result_m,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [XLEN-1:0]   result_w,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    output logic [XLEN-1:0]   src_a_e,
    output logic [XLEN-1:0]   src_b_e,
    output logic [XLEN-1:0]   write_data_e,
    output logic [2:0]        alu_control_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   imm_ext_e,
    output logic [REG_AW-1:0] rs1_e,
    output logic [REG_AW-1:0] rs2_e,
    output logic [REG_AW-1:0] rd_e,
    output logic              reg_write_e,
    output logic              mem_write_e,
    output logic              branch_e,
    output logic              jump_e,
    output logic              valid_e,
    output logic [1:0]        result_src_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e
);
    import riscv_pkg::*;

    ctrl_t             ctrl_d;
    ctrl_t             ctrl_q;
    logic [XLEN-1:0]   rd1_q;
    logic [XLEN-1:0]   rd2_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   pc_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [REG_AW-1:0] rd_q;
    logic              refresh_a;
    logic              refresh_b;
    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;

    assign ctrl_d = '{
        valid:       valid_d,
        reg_write:   reg_write_d,
        mem_write:   mem_write_d,
        branch:      branch_d,
        jump:        jump_d,
        alu_src:     alu_src_d,
        result_src:  result_src_d,
        alu_control: alu_control_d
    };

    // A WB write to a held source register must land in the held copy, else it is lost
    assign refresh_a = reg_write_w && (rd_w != '0) && (rd_w == rs1_q);
    assign refresh_b = reg_write_w && (rd_w != '0) && (rd_w == rs2_q);

    // EX-slot register: reset > flush (bubble) > stall (hold + refresh) > capture
    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            ctrl_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            pc_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
        end else if (stall_e) begin
            if (refresh_a) rd1_q <= result_w;
            if (refresh_b) rd2_q <= result_w;
        end else begin
            ctrl_q <= ctrl_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_ext_d;
            pc_q   <= pc_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            rd_q   <= rd_d;
        end
    end

    forward_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .rs          (rs1_q),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .sel_c       (fwd_a)
    );

    forward_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .rs          (rs2_q),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .sel_c       (fwd_b)
    );

    // Forwarded operand selection
    always_comb begin
        op_a = rd1_q;
        op_b = rd2_q;
        case (fwd_a)
            FWD_M:   op_a = alu_result_m;
            FWD_W:   op_a = result_w;
            default: op_a = rd1_q;
        endcase
        case (fwd_b)
            FWD_M:   op_b = alu_result_m;
            FWD_W:   op_b = result_w;
            default: op_b = rd2_q;
        endcase
    end

    assign src_a_e       = op_a;
    assign write_data_e  = op_b;
    assign src_b_e       = ctrl_q.alu_src ? imm_q : op_b;
    assign forward_a_e   = 2'(fwd_a);
    assign forward_b_e   = 2'(fwd_b);
    assign alu_control_e = ctrl_q.alu_control;
    assign result_src_e  = ctrl_q.result_src;
    assign reg_write_e   = ctrl_q.reg_write;
    assign mem_write_e   = ctrl_q.mem_write;
    assign branch_e      = ctrl_q.branch;
    assign jump_e        = ctrl_q.jump;
    assign valid_e       = ctrl_q.valid;
    assign pc_e          = pc_q;
    assign imm_ext_e     = imm_q;
    assign rs1_e         = rs1_q;
    assign rs2_e         = rs2_q;
    assign rd_e          = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table through a scoreboard plus corner sequences.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_e, flush_e, valid_d;
    logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [2:0]  alu_control_d;
    logic        alu_src_d, reg_write_d, mem_write_d, branch_d, jump_d;
    logic [1:0]  result_src_d;
    logic [31:0] alu_result_m, result_w;
    logic [4:0]  rd_m, rd_w;
    logic        reg_write_m, reg_write_w;
    logic [31:0] src_a_e, src_b_e, write_data_e, pc_e, imm_ext_e;
    logic [2:0]  alu_control_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        reg_write_e, mem_write_e, branch_e, jump_e, valid_e;
    logic [1:0]  result_src_e, forward_a_e, forward_b_e;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .imm_ext_d(imm_ext_d), .pc_d(pc_d), .alu_control_d(alu_control_d),
        .alu_src_d(alu_src_d), .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
        .branch_d(branch_d), .jump_d(jump_d), .result_src_d(result_src_d),
        .alu_result_m(alu_result_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
        .result_w(result_w), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .src_a_e(src_a_e), .src_b_e(src_b_e), .write_data_e(write_data_e),
        .alu_control_e(alu_control_e), .pc_e(pc_e), .imm_ext_e(imm_ext_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
        .mem_write_e(mem_write_e), .branch_e(branch_e), .jump_e(jump_e), .valid_e(valid_e),
        .result_src_e(result_src_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e)
    );

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] rd1, rd2, imm;
        logic        alu_src;
        logic [31:0] alu_res_m;
        logic [4:0]  rd_m;
        logic        rwm;
        logic [31:0] res_w;
        logic [4:0]  rd_w;
        logic        rww;
        logic [1:0]  fa, fb;
        logic [31:0] src_a, src_b, wd;
    } vec_t;

    typedef struct {
        logic [1:0]  fa, fb;
        logic [31:0] src_a, src_b, wd, pc;
        logic [4:0]  rd;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall_e = 0; flush_e = 0; valid_d = 0;
        rd1_d = 0; rd2_d = 0; imm_ext_d = 0; pc_d = 0;
        rs1_d = 0; rs2_d = 0; rd_d = 0; alu_control_d = 0;
        alu_src_d = 0; reg_write_d = 0; mem_write_d = 0; branch_d = 0; jump_d = 0;
        result_src_d = 0; alu_result_m = 0; rd_m = 0; reg_write_m = 0;
        result_w = 0; rd_w = 0; reg_write_w = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        idle_inputs();

        //            rs1 rs2 rd1       rd2       imm           asrc alu_m     rd_m rwm res_w     rd_w rww fa     fb     src_a     src_b         wd
        vecs[0] = '{5,  6,  32'h99,   32'h66,   32'h4,        0, 32'h10,   5,  1, 32'h20,   5,  1, 2'b10, 2'b00, 32'h10,   32'h66,       32'h66};
        vecs[1] = '{5,  6,  32'h99,   32'h66,   32'h4,        0, 32'h10,   5,  0, 32'h20,   5,  1, 2'b01, 2'b00, 32'h20,   32'h66,       32'h66};
        vecs[2] = '{1,  0,  32'h11,   32'h22,   32'h4,        0, 32'h10,   0,  1, 32'h20,   0,  1, 2'b00, 2'b00, 32'h11,   32'h22,       32'h22};
        vecs[3] = '{4,  3,  32'h44,   32'h33,   32'hFFFFF800, 1, 32'hCAFE, 3,  1, 32'hBEEF, 4,  1, 2'b01, 2'b10, 32'hBEEF, 32'hFFFFF800, 32'hCAFE};
        vecs[4] = '{8,  9,  32'h88,   32'h99,   32'h4,        0, 32'h10,   8,  0, 32'h20,   9,  0, 2'b00, 2'b00, 32'h88,   32'h99,       32'h99};
        vecs[5] = '{12, 12, 32'hC0,   32'hC1,   32'h4,        0, 32'h10,   13, 1, 32'h1234, 12, 1, 2'b01, 2'b01, 32'h1234, 32'h1234,     32'h1234};

        // Reset held two cycles with live decode inputs: EX slot must stay a bubble
        reset = 1; valid_d = 1; reg_write_d = 1; mem_write_d = 1;
        pc_d = 32'hDEAD0000; rs1_d = 3; rd1_d = 32'h77; rd_d = 4;
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_valid", 32'(valid_e), 32'h0);
            check("rst_reg_write", 32'(reg_write_e), 32'h0);
            check("rst_mem_write", 32'(mem_write_e), 32'h0);
            check("rst_pc", pc_e, 32'h0);
            check("rst_src_a", src_a_e, 32'h0);
        end
        reset = 0;
        step();
        check("post_rst_valid", 32'(valid_e), 32'h1);
        check("post_rst_pc", pc_e, 32'hDEAD0000);
        check("post_rst_rd", 32'(rd_e), 32'h4);
        check("post_rst_src_a", src_a_e, 32'h77);

        // Table vectors through the scoreboard
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            valid_d = 1; reg_write_d = 1;
            rs1_d = vecs[i].rs1; rs2_d = vecs[i].rs2;
            rd1_d = vecs[i].rd1; rd2_d = vecs[i].rd2;
            imm_ext_d = vecs[i].imm; alu_src_d = vecs[i].alu_src;
            rd_d = 5'(i + 20); pc_d = 32'h1000 + 32'(i * 4);
            alu_result_m = vecs[i].alu_res_m; rd_m = vecs[i].rd_m; reg_write_m = vecs[i].rwm;
            result_w = vecs[i].res_w; rd_w = vecs[i].rd_w; reg_write_w = vecs[i].rww;
            sb.push_back('{vecs[i].fa, vecs[i].fb, vecs[i].src_a, vecs[i].src_b,
                           vecs[i].wd, 32'h1000 + 32'(i * 4), 5'(i + 20)});
            step();
            e = sb.pop_front();
            check($sformatf("v%0d_fwd_a", i), 32'(forward_a_e), 32'(e.fa));
            check($sformatf("v%0d_fwd_b", i), 32'(forward_b_e), 32'(e.fb));
            check($sformatf("v%0d_src_a", i), src_a_e, e.src_a);
            check($sformatf("v%0d_src_b", i), src_b_e, e.src_b);
            check($sformatf("v%0d_wdata", i), write_data_e, e.wd);
            check($sformatf("v%0d_pc", i), pc_e, e.pc);
            check($sformatf("v%0d_rd", i), 32'(rd_e), 32'(e.rd));
        end

        // Stall refresh: WB writes x7 while x7 is held in the EX slot
        idle_inputs();
        valid_d = 1; rs1_d = 7; rd1_d = 32'h1111; rs2_d = 9; rd2_d = 32'h2222; pc_d = 32'h2000;
        step();
        stall_e = 1; rs1_d = 2; rd1_d = 32'h5555; rs2_d = 2; rd2_d = 32'h6666; pc_d = 32'h3000;
        rd_w = 7; reg_write_w = 1; result_w = 32'hABCD;
        step();
        reg_write_w = 0; result_w = 32'h0;
        step();
        check("stall_rs1_held", 32'(rs1_e), 32'h7);
        check("stall_pc_held", pc_e, 32'h2000);
        check("stall_fwd_a", 32'(forward_a_e), 32'h0);
        check("stall_refresh_src_a", src_a_e, 32'hABCD);
        check("stall_no_refresh_src_b", src_b_e, 32'h2222);
        stall_e = 0;
        step();
        check("unstall_pc", pc_e, 32'h3000);
        check("unstall_src_a", src_a_e, 32'h5555);

        // Flush and stall together: flush wins, bubble loaded
        flush_e = 1; stall_e = 1; valid_d = 1; reg_write_d = 1; mem_write_d = 1;
        branch_d = 1; rd_d = 5; pc_d = 32'h4000;
        step();
        check("flush_valid", 32'(valid_e), 32'h0);
        check("flush_reg_write", 32'(reg_write_e), 32'h0);
        check("flush_mem_write", 32'(mem_write_e), 32'h0);
        check("flush_branch", 32'(branch_e), 32'h0);
        check("flush_rd", 32'(rd_e), 32'h0);
        check("flush_pc", pc_e, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
